// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds WIDTH-bit operands CHUNK bits per clock, with a Start/Busy/Done handshake.
// Define SERIAL_CHUNK_ADDER_SUB_EN to add a Sub input that selects A + ~B + 1.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, partial, full, b_in;
  logic [CW-1:0] cnt;
  logic [CHUNK:0] chunk_sum;
  logic carry, c_in, last, accept;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign b_in = Sub ? ~B : B;
  assign c_in = Sub ? 1'b1 : Cin;
`else
  assign b_in = B;
  assign c_in = Cin;
`endif
  assign last   = cnt == CW'(N - 1);
  assign accept = Start && state != ADD;
  always_comb begin
    chunk_sum = {1'b0, a_r[cnt*CHUNK +: CHUNK]} + {1'b0, b_r[cnt*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);
    full = partial;
    full[cnt*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    Busy = state == ADD;
    Done = state == DONE;
    if (state == ADD) state_nx = last ? DONE : ADD;
    else state_nx = Start ? ADD : IDLE;
  end
  // Overflow: the carry into the MSB is recovered as a^b^s at that bit.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      cnt <= '0;
      partial <= '0;
      S <= '0;
      Cout <= 1'b0;
      Overflow <= 1'b0;
    end else if (accept) begin
      a_r <= A;
      b_r <= b_in;
      carry <= c_in;
      cnt <= '0;
      partial <= '0;
    end else if (state == ADD) begin
      partial <= full;
      carry <= chunk_sum[CHUNK];
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) begin
        S <= full;
        Cout <= chunk_sum[CHUNK];
        Overflow <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ full[WIDTH-1] ^ chunk_sum[CHUNK];
      end
    end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed checks plus a cycle-by-cycle reference model for serial_chunk_adder.
module tb_serial_chunk_adder;
  localparam int N16 = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic busy, done, cout, ovf;
  logic [15:0] s;
  logic st8 = 1'b0, ci8 = 1'b0, bz8, dn8, co8, ov8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic st12 = 1'b0, ci12 = 1'b0, bz12, dn12, co12, ov12;
  logic [11:0] a12 = '0, b12 = '0, s12;
  int checks = 0, failures = 0;
  bit live = 1'b0;
  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .Sub(sub),
`endif
    .Busy(busy), .Done(done), .S(s), .Cout(cout), .Overflow(ovf));

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u8 (
    .Clk(clk), .Reset(rst), .Start(st8), .A(a8), .B(b8), .Cin(ci8),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .Sub(1'b0),
`endif
    .Busy(bz8), .Done(dn8), .S(s8), .Cout(co8), .Overflow(ov8));

  serial_chunk_adder #(.WIDTH(12), .CHUNK(1)) u12 (
    .Clk(clk), .Reset(rst), .Start(st12), .A(a12), .B(b12), .Cin(ci12),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .Sub(1'b0),
`endif
    .Busy(bz12), .Done(dn12), .S(s12), .Cout(co12), .Overflow(ov12));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: an accepted op at edge k occupies edges k..k+N-1 and
  // its plain-arithmetic result becomes visible from edge k+N onward.
  int e = 0, k = 0;
  bit op = 1'b0;
  logic [15:0] r_s, m_s, bb;
  logic r_c, r_o, m_c, m_o, cc;
  logic [16:0] t;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0; k = 0; op = 0; m_s = '0; m_c = 0; m_o = 0;
    end else begin
      if (op && e + 1 == k + N16) begin
        m_s = r_s; m_c = r_c; m_o = r_o;
      end
      if (start && !(op && e >= k && e < k + N16)) begin
        bb = b; cc = cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        if (sub) begin bb = ~b; cc = 1'b1; end
`endif
        t = {1'b0, a} + {1'b0, bb} + 17'(cc);
        r_s = t[15:0];
        r_c = t[16];
        r_o = (a[15] == bb[15]) && (t[15] != a[15]);
        k = e + 1;
        op = 1'b1;
      end
      e++;
    end
  end

  always @(negedge clk) if (live) begin
    chk("cyc_busy", busy, op && e >= k && e < k + N16);
    chk("cyc_done", done, op && e == k + N16);
    chk("cyc_s", s, m_s);
    chk("cyc_cout", cout, m_c);
    chk("cyc_ovf", ovf, m_o);
  end

  task automatic op16(input logic [15:0] av, bv, input logic cv, sv,
                      input logic [15:0] xs, input logic xc, xo, input string nm);
    int c, nb;
    @(negedge clk); a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    @(negedge clk); start = 1'b0; c = 1; nb = 0;
    while (!done && c < 20) begin
      if (busy) nb++;
      @(negedge clk); c++;
    end
    chk({nm, "_lat"}, c, 5);
    chk({nm, "_busycnt"}, nb, 4);
    chk({nm, "_s"}, s, xs);
    chk({nm, "_cout"}, cout, xc);
    chk({nm, "_ovf"}, ovf, xo);
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while (!done && c < 40) begin @(negedge clk); c++; end
    chk({nm, "_done"}, done, 1);
  endtask

  task automatic run8;
    int c;
    logic [8:0] r;
    @(negedge clk); a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); st8 = 1'b1;
    @(negedge clk); st8 = 1'b0; c = 1;
    while (!dn8 && c < 20) begin @(negedge clk); c++; end
    r = {1'b0, a8} + {1'b0, b8} + 9'(ci8);
    chk("w8_lat", c, 2);
    chk("w8_s", s8, r[7:0]);
    chk("w8_cout", co8, r[8]);
    chk("w8_ovf", ov8, (a8[7] == b8[7]) && (r[7] != a8[7]));
  endtask

  task automatic run12;
    int c;
    logic [12:0] r;
    @(negedge clk); a12 = 12'($urandom); b12 = 12'($urandom); ci12 = 1'($urandom); st12 = 1'b1;
    @(negedge clk); st12 = 1'b0; c = 1;
    while (!dn12 && c < 40) begin @(negedge clk); c++; end
    r = {1'b0, a12} + {1'b0, b12} + 13'(ci12);
    chk("w12_lat", c, 13);
    chk("w12_s", s12, r[11:0]);
    chk("w12_cout", co12, r[12]);
    chk("w12_ovf", ov12, (a12[11] == b12[11]) && (r[11] != a12[11]));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    rst = 1'b0;
    live = 1'b1;
    op16(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, "basic");
    op16(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, "wrap");
    op16(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, "posovf");
    op16(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, "negovf");
    op16(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0, "allones");
    op16(16'h00FF, 16'h0000, 1, 0, 16'h0100, 0, 0, "cinprop");
    // A second Start during ADD must not disturb the first operation.
    @(negedge clk); a = 16'h0001; b = 16'h0001; cin = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("ign");
    chk("ign_s", s, 16'h0002);
    @(negedge clk); a = 16'h0100; b = 16'h0200; start = 1'b1;
    wait_done("b2b1");
    chk("b2b1_s", s, 16'h0300);
    a = 16'h0003; b = 16'h0004;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    chk("b2b_nodone", done, 0);
    start = 1'b0;
    wait_done("b2b2");
    chk("b2b2_s", s, 16'h0007);
    @(negedge clk); a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_s", s, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    op16(16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0, "postrst");
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    op16(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, "sub1");
    op16(16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0, "sub2");
    op16(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, "subovf");
    sub = 1'b0;
`endif
    for (int i = 0; i < 4; i++) run8;
    for (int i = 0; i < 4; i++) run12;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Start  input  1  request; sampled on rising Clk.
REQ-006 SHALL have ports A, B  input  WIDTH  operands, sampled only when Start is accepted.
REQ-007 SHALL have port Cin  input  1  carry-in, sampled with A/B.
REQ-008 SHALL have port Busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port S  output  WIDTH  registered sum.
REQ-011 SHALL have ports Cout, Overflow  output  1 each  final carry-out; signed overflow.

Function
REQ-012 SHALL implement FSM states IDLE, ADD, DONE; N = WIDTH/CHUNK.
REQ-013 Start high at an edge in IDLE or DONE SHALL latch A, B, Cin, clear chunk counter to 0, enter ADD.
REQ-014 Start in ADD SHALL be ignored; latched operands and progress SHALL be unaffected.
REQ-015 Each ADD cycle SHALL add chunk i (bits i*CHUNK+CHUNK-1 .. i*CHUNK) of latched A and B plus carry register, store the CHUNK sum bits in an internal partial register, update the carry register, increment i.
REQ-016 Chunk 0 SHALL use latched Cin as carry; chunk i>0 SHALL use carry-out of chunk i-1.
REQ-017 After the edge processing chunk N-1, FSM SHALL enter DONE and load S, Cout, Overflow in that same edge.
REQ-018 Latency: Start accepted at edge k -> Done high in the cycle following edge k+N; Busy high in cycles following edges k .. k+N-1.
REQ-019 Done SHALL be high only in DONE (exactly one cycle); DONE SHALL go to IDLE unless Start is high, then to ADD.
REQ-020 S, Cout, Overflow SHALL hold their values until the next completion or Reset; partial results SHALL never appear on S.
REQ-021 Overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; bit WIDTH carry goes to Cout only.
REQ-023 CHUNK = WIDTH SHALL give N = 1 (single ADD cycle) with identical handshake.

Reset
REQ-024 Reset high SHALL immediately, independent of Clk, force state IDLE, Busy=0, Done=0, S=0, Cout=0, Overflow=0, counter, carry and operand registers to 0.
REQ-025 Reset mid-operation SHALL abandon it; no Done pulse for that operation; Start SHALL be honoured at the first edge after Reset deasserts.

Configuration
REQ-026 Macro SERIAL_CHUNK_ADDER_SUB_EN SHALL compile in a 1-bit input Sub, sampled with A/B.
REQ-027 With the macro and Sub=1, operation SHALL be A + ~B + 1 (Cin ignored); Cout=1 means no borrow; Overflow per REQ-021 on the inverted operand. Sub=0 behaves as without the macro.
REQ-028 Without the macro, port Sub and all inversion logic SHALL be absent; operation is always A + B + Cin.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-029 A=0x1234, B=0x4321, Cin=0, Start 1 cycle -> Busy 4 cycles, Done on 5th cycle after Start edge, S=0x5555, Cout=0, Overflow=0.
REQ-030 A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Overflow=0; A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, Overflow=1.
REQ-031 Start with A=0x0001,B=0x0001, then Start with A=0xAAAA,B=0x5555 two cycles later -> second ignored, S=0x0002; Start held high through DONE -> back-to-back op with no IDLE cycle.
REQ-032 Reset asserted asynchronously after 2 ADD cycles -> all outputs 0 immediately, no Done; new op after release completes correctly.
REQ-033 With SERIAL_CHUNK_ADDER_SUB_EN: A=0x0005, B=0x0007, Sub=1 -> S=0xFFFE, Cout=0; A=0x0007, B=0x0005 -> S=0x0002, Cout=1.
REQ-034 WIDTH=8, CHUNK=8 and WIDTH=12, CHUNK=1: random operands vs reference sum -> results match, latency N+1 cycles.
